// File: rtl/seq_mult8_scheduler.sv
// seq_mult8_scheduler: time-multiplexed 8x8 unsigned multiplier controller.
// One 4x4 partial-product core is shared across the LL, LH, HL and HH nibble
// quadrants, one quadrant per cycle, with optional per-quadrant LSB truncation.
// Optional feature macro: SEQ_MULT8_SKIP_ZERO_EN (skip quadrants with a zero nibble).
module seq_mult8_scheduler #(
    parameter int unsigned TRUNC_BITS = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [7:0]  a,
    input  logic [7:0]  b,
    input  logic [3:0]  approx_mask,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] p,
    output logic        busy
);

    typedef enum logic [2:0] {
        StIdle,
        StQLl,
        StQLh,
        StQHl,
        StQHh,
        StDone
    } state_t;

    state_t      state;
    logic [7:0]  a_q;
    logic [7:0]  b_q;
    logic [3:0]  mask_q;
    logic [3:0]  skip_q;
    logic [15:0] acc;

    logic [3:0]  nib_a;
    logic [3:0]  nib_b;
    logic [3:0]  shamt;
    logic        trunc_en;
    logic [7:0]  pp_raw;
    logic [7:0]  keep_mask;
    logic [7:0]  pp_trunc;
    logic [15:0] pp_shifted;
    logic [15:0] acc_sum;
    logic [3:0]  skip_in;
    state_t      first_state;
    state_t      next_comp;

    // Quadrants whose product is known to be zero from the incoming operands
`ifdef SEQ_MULT8_SKIP_ZERO_EN
    always_comb begin
        skip_in[0] = (a[3:0] == 4'd0) || (b[3:0] == 4'd0);
        skip_in[1] = (a[3:0] == 4'd0) || (b[7:4] == 4'd0);
        skip_in[2] = (a[7:4] == 4'd0) || (b[3:0] == 4'd0);
        skip_in[3] = (a[7:4] == 4'd0) || (b[7:4] == 4'd0);
    end
`else
    always_comb begin
        skip_in = 4'b0000;
    end
`endif

    // First quadrant to visit after acceptance; an all-skipped operation passes
    // through LL once (adding zero) so the result appears one edge after acceptance
    always_comb begin
        first_state = StQLl;
        if (!skip_in[0]) begin
            first_state = StQLl;
        end else if (!skip_in[1]) begin
            first_state = StQLh;
        end else if (!skip_in[2]) begin
            first_state = StQHl;
        end else if (!skip_in[3]) begin
            first_state = StQHh;
        end
    end

    // Next quadrant after the current one, skipping flagged quadrants
    always_comb begin
        next_comp = StDone;
        case (state)
            StQLl: begin
                if (!skip_q[1]) next_comp = StQLh;
                else if (!skip_q[2]) next_comp = StQHl;
                else if (!skip_q[3]) next_comp = StQHh;
            end
            StQLh: begin
                if (!skip_q[2]) next_comp = StQHl;
                else if (!skip_q[3]) next_comp = StQHh;
            end
            StQHl: begin
                if (!skip_q[3]) next_comp = StQHh;
            end
            default: next_comp = StDone;
        endcase
    end

    // Shared 4x4 core: nibble select, truncation, shift and accumulate
    always_comb begin
        nib_a    = a_q[3:0];
        nib_b    = b_q[3:0];
        shamt    = 4'd0;
        trunc_en = mask_q[0];
        case (state)
            StQLh: begin
                nib_a    = a_q[3:0];
                nib_b    = b_q[7:4];
                shamt    = 4'd4;
                trunc_en = mask_q[1];
            end
            StQHl: begin
                nib_a    = a_q[7:4];
                nib_b    = b_q[3:0];
                shamt    = 4'd4;
                trunc_en = mask_q[2];
            end
            StQHh: begin
                nib_a    = a_q[7:4];
                nib_b    = b_q[7:4];
                shamt    = 4'd8;
                trunc_en = mask_q[3];
            end
            default: ;
        endcase
        pp_raw     = {4'b0000, nib_a} * {4'b0000, nib_b};
        keep_mask  = 8'hFF << TRUNC_BITS;
        pp_trunc   = trunc_en ? (pp_raw & keep_mask) : pp_raw;
        pp_shifted = {8'h00, pp_trunc} << shamt;
        acc_sum    = acc + pp_shifted;
    end

    // Control FSM with registered handshake outputs and result
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= StIdle;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            p         <= 16'h0000;
            acc       <= 16'h0000;
            a_q       <= 8'h00;
            b_q       <= 8'h00;
            mask_q    <= 4'h0;
            skip_q    <= 4'h0;
        end else begin
            case (state)
                StIdle: begin
                    if (in_valid) begin
                        a_q      <= a;
                        b_q      <= b;
                        mask_q   <= approx_mask;
                        skip_q   <= skip_in;
                        acc      <= 16'h0000;
                        state    <= first_state;
                        in_ready <= 1'b0;
                        busy     <= 1'b1;
                    end
                end
                StQLl, StQLh, StQHl, StQHh: begin
                    acc   <= acc_sum;
                    state <= next_comp;
                    if (next_comp == StDone) begin
                        out_valid <= 1'b1;
                        p         <= acc_sum;
                    end
                end
                StDone: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        busy      <= 1'b0;
                        state     <= StIdle;
                    end
                end
                default: begin
                    state     <= StIdle;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_mult8_scheduler.sv
// Scoreboard bench for seq_mult8_scheduler: the driver pushes hand-computed
// results and their expected out_valid cycle; a monitor pops and compares.
module tb_seq_mult8_scheduler;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  a;
    logic [7:0]  b;
    logic [3:0]  approx_mask;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] p;
    logic        busy;

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;

    typedef struct {
        logic [7:0]  va;
        logic [7:0]  vb;
        logic [3:0]  vm;
        logic [15:0] vp;
        int          lat_skip;
        int          lat_full;
    } vec_t;

    typedef struct {
        logic [15:0] ep;
        int          ecyc;
    } exp_t;

    exp_t exp_q[$];
    vec_t vecs[9];

    seq_mult8_scheduler #(.TRUNC_BITS(2)) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .a           (a),
        .b           (b),
        .approx_mask (approx_mask),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .p           (p),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_cmp++;
        if (act !== expv) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    task automatic send(input vec_t v);
        bit ok;
        int lat;
        exp_t e;
        ok = 1'b0;
`ifdef SEQ_MULT8_SKIP_ZERO_EN
        lat = v.lat_skip;
`else
        lat = v.lat_full;
`endif
        @(negedge clk);
        a           = v.va;
        b           = v.vb;
        approx_mask = v.vm;
        in_valid    = 1'b1;
        for (int i = 0; i < 50 && !ok; i++) begin
            if (in_ready) begin
                @(posedge clk);
                #1;
                ok     = 1'b1;
                e.ep   = v.vp;
                e.ecyc = cyc + lat;
                exp_q.push_back(e);
                in_valid = 1'b0;
            end else begin
                @(negedge clk);
            end
        end
        if (!ok) begin
            in_valid = 1'b0;
            chk("accept_timeout", 32'd0, 32'd1);
        end
    endtask

    task automatic wait_done();
        bit done;
        done = 1'b0;
        for (int i = 0; i < 40 && !done; i++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && !out_valid) done = 1'b1;
        end
        if (!done) chk("result_timeout", 32'd0, 32'd1);
    endtask

    // Monitor: compare every presented result against the scoreboard head
    initial begin
        bit seen;
        seen = 1'b0;
        forever begin
            @(negedge clk);
            #2;
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_result", {16'h0, p}, 32'hFFFF_FFFF);
                end else begin
                    if (!seen) begin
                        seen = 1'b1;
                        chk("latency_cycle", exp_q[0].ecyc, cyc);
                        chk("in_ready_in_done", {31'b0, in_ready}, 32'd0);
                        chk("busy_in_done", {31'b0, busy}, 32'd1);
                    end
                    chk("product", {16'h0, p}, {16'h0, exp_q[0].ep});
                    if (out_ready) begin
                        void'(exp_q.pop_front());
                        seen = 1'b0;
                    end
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "global timeout");
    end

    initial begin
        vecs[0] = '{8'hFF, 8'hFF, 4'h0, 16'hFE01, 4, 4};
        vecs[1] = '{8'h0F, 8'h0F, 4'h1, 16'h00E0, 1, 4};
        vecs[2] = '{8'hFF, 8'hFF, 4'hF, 16'hFCE0, 4, 4};
        vecs[3] = '{8'hA5, 8'h3C, 4'h0, 16'h26AC, 4, 4};
        vecs[4] = '{8'h12, 8'h34, 4'hA, 16'h0088, 4, 4};
        vecs[5] = '{8'h80, 8'h02, 4'h0, 16'h0100, 1, 4};
        vecs[6] = '{8'h03, 8'h05, 4'h0, 16'h000F, 1, 4};
        vecs[7] = '{8'h00, 8'h37, 4'h0, 16'h0000, 1, 4};
        vecs[8] = '{8'h10, 8'h10, 4'h0, 16'h0100, 1, 4};

        rst         = 1'b1;
        in_valid    = 1'b0;
        a           = 8'h00;
        b           = 8'h00;
        approx_mask = 4'h0;
        out_ready   = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_in_ready", {31'b0, in_ready}, 32'd1);
        chk("reset_out_valid", {31'b0, out_valid}, 32'd0);
        chk("reset_p", {16'h0, p}, 32'd0);
        chk("reset_busy", {31'b0, busy}, 32'd0);
        rst = 1'b0;

        // Plain and truncated products with an always-ready sink
        for (int i = 0; i < 8; i++) begin
            send(vecs[i]);
            wait_done();
            chk("idle_in_ready", {31'b0, in_ready}, 32'd1);
            chk("idle_busy", {31'b0, busy}, 32'd0);
        end

        // Backpressure: result held, new requests ignored
        out_ready = 1'b0;
        send(vecs[0]);
        for (int i = 0; i < 20 && !out_valid; i++) @(negedge clk);
        chk("bp_out_valid_seen", {31'b0, out_valid}, 32'd1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            in_valid = 1'b1;
            a        = 8'h02;
            b        = 8'h03;
            #1;
            chk("bp_in_ready", {31'b0, in_ready}, 32'd0);
            chk("bp_p_held", {16'h0, p}, 32'h0000_FE01);
        end
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        wait_done();
        chk("bp_return_in_ready", {31'b0, in_ready}, 32'd1);
        chk("bp_p_kept", {16'h0, p}, 32'h0000_FE01);

        // Reset while in the HL quadrant discards the operation
        send(vecs[0]);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b1;
        exp_q.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("midrst_out_valid", {31'b0, out_valid}, 32'd0);
        chk("midrst_p", {16'h0, p}, 32'd0);
        chk("midrst_busy", {31'b0, busy}, 32'd0);
        chk("midrst_in_ready", {31'b0, in_ready}, 32'd1);
        send(vecs[8]);
        wait_done();

        repeat (10) @(negedge clk);
        chk("scoreboard_drained", exp_q.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
